mips_16_run_ctrl: RTL and testbench
===================================

// Module: mips_16_run_ctrl
// PURPOSE
//  Boot/run sequencer for mips_16_core_top: streams a program into instruction ROM write port, pulses core reset,
//  runs the core for a bounded number of cycles, then freezes it so registers/data RAM can be inspected.
//  Sits between host/debug logic and the core; owns the core's reset and pipeline-enable during runs.
// PARAMETERS
//  PC_WIDTH     8   PC / imem address width (matches `PC_WIDTH)
//  INSTR_WIDTH  16  instruction word width
//  CYC_W        16  run-cycle counter / limit width
//  RST_CYCLES   2   cycles core_rst held high at run start (>=1)
// PORTS
//  clk          in   1            clock
//  rst          in   1            reset, asynchronous, active-high
//  start_load   in   1            pulse: begin program load (sampled in IDLE only)
//  load_len     in   PC_WIDTH+1   number of words to load, 1..2^PC_WIDTH; latched with start_load
//  load_valid   in   1            stream word valid
//  load_ready   out  1            stream word ready
//  load_data    in   INSTR_WIDTH  stream word
//  imem_we      out  1            imem write strobe
//  imem_waddr   out  PC_WIDTH     imem write address
//  imem_wdata   out  INSTR_WIDTH  imem write data
//  start_run    in   1            pulse: begin run (sampled in IDLE only)
//  run_limit    in   CYC_W        run length in core cycles, 0 = unlimited; latched with start_run
//  abort        in   1            level: terminate LOAD/RSTP/RUN
//  pc           in   PC_WIDTH     core current PC
//  core_rst     out  1            core reset
//  core_en      out  1            core pipeline enable
//  busy         out  1            state != IDLE
//  done         out  1            1-cycle pulse at end of load or run
//  halt_cause   out  2            0 LOAD_DONE, 1 LIMIT, 2 BREAK, 3 ABORT; valid with done, held until next done
//  cycles       out  CYC_W        core_en cycles of last/current run; cleared at start_run; saturates at all-ones
// BEHAVIOUR
//  Reset: state IDLE; core_rst=1, core_en=0, load_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0,
//   done=0, halt_cause=0, cycles=0.
//  States IDLE, LOAD, RSTP, RUN, HALT.
//  IDLE: start_load && load_len!=0 -> LOAD, word counter=0. start_load with load_len==0 ignored (no done).
//   start_run -> RSTP, cycles=0. start_load and start_run together: load wins, run dropped.
//   abort in IDLE ignored. Outputs core_rst/core_en keep the values left by the previous state (0/0 after a run).
//  LOAD: core_rst=1, core_en=0, load_ready=1. Handshake = load_valid&&load_ready; combinational, same cycle:
//   imem_we=1, imem_waddr=counter, imem_wdata=load_data; counter++. Last handshake (counter==load_len-1)
//   -> IDLE next cycle with done=1, halt_cause=0. load_ready deasserts in that IDLE cycle. load_len=2^PC_WIDTH
//   writes every address, no wrap. Valid gaps are allowed; no timeout.
//  RSTP: core_rst=1, core_en=0 for exactly RST_CYCLES cycles -> RUN.
//  RUN: core_rst=0, core_en=1; cycles++ each RUN cycle. Halt when cycles (post-increment)==limit (limit!=0):
//   exactly run_limit cycles with core_en=1, then HALT.
//  HALT: one cycle; core_en=0, core_rst=0 (core state preserved); done=1 with cause -> IDLE.
//  abort in LOAD/RSTP/RUN: next state HALT with cause 3; an imem write coinciding with abort still happens.
//  Priority in same cycle: ABORT > BREAK > LIMIT.
//  Latency start_run -> first core_en cycle = 1+RST_CYCLES cycles.
// CONFIGURATION
//  MIPS16_RUNCTL_BREAK_EN defined: adds ports bp_en (in,1) and bp_addr (in,PC_WIDTH). In RUN, pc==bp_addr with
//   bp_en=1 -> HALT with cause 2. That cycle still counts in cycles. Breakpoint not checked in the first
//   RUN cycle after RSTP, so a run can start at a breakpoint address.
//  Not defined: ports absent; cause 2 never produced.
// TESTING
//  1 load_len=5, words 0x1111..0x5555 with random valid gaps -> imem addr0..4 written in order, exactly 5 imem_we,
//    done+cause0 one cycle after 5th handshake.
//  2 load_len=256 (PC_WIDTH=8) -> addr 0..255 written, counter no wrap, single done.
//  3 start_run run_limit=10, RST_CYCLES=2 -> core_rst high 2 cycles, core_en high exactly 10, cycles=10,
//    done cause1, core_rst=0 afterwards; fibonacci prog regs unchanged across idle cycles.
//  4 run_limit=0, abort after 37 RUN cycles -> cause3, cycles=37; abort mid-LOAD after 3 words ->
//    3 writes, cause3.
//  5 MIPS16_RUNCTL_BREAK_EN, bp_addr=6, limit=50 -> halt first time pc==6, cause2; bp and limit same cycle
//    -> cause2.
//  6 rst asserted mid-RUN and mid-LOAD -> all outputs at reset values asynchronously; start_load+start_run
//    together -> LOAD only.

Source files
------------

// File: rtl/mips_16_run_ctrl.sv
// Boot/run sequencer for mips_16_core_top: program load into imem, core reset pulse, bounded run, freeze.
// Define MIPS16_RUNCTL_BREAK_EN to add the PC breakpoint ports (bp_en, bp_addr) and halt cause 2.
module mips_16_run_ctrl #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int CYC_W       = 16,
  parameter int RST_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_load,
  input  logic [PC_WIDTH:0]      load_len,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [INSTR_WIDTH-1:0] load_data,
  output logic                   imem_we,
  output logic [PC_WIDTH-1:0]    imem_waddr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  input  logic                   start_run,
  input  logic [CYC_W-1:0]       run_limit,
  input  logic                   abort,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic                   core_rst,
  output logic                   core_en,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             halt_cause,
  output logic [CYC_W-1:0]       cycles
`ifdef MIPS16_RUNCTL_BREAK_EN
  ,
  input  logic                   bp_en,
  input  logic [PC_WIDTH-1:0]    bp_addr
`endif
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RSTP, S_RUN, S_HALT} state_t;
  typedef enum logic [1:0] {C_LOAD_DONE, C_LIMIT, C_BREAK, C_ABORT} cause_t;

  state_t              r_state, w_next;
  cause_t              r_cause, w_cause;
  logic [PC_WIDTH:0]   r_cnt, r_len;
  logic [CYC_W-1:0]    r_limit, r_cycles, w_cyc_inc;
  logic [RC_W-1:0]     r_rcnt;
  logic                r_core_rst, r_core_en, r_done;
  logic                w_hs, w_bp, w_load_end, w_done_nxt;

  assign w_hs      = (r_state == S_LOAD) && load_valid;
  assign w_cyc_inc = (&r_cycles) ? r_cycles : r_cycles + CYC_W'(1);

`ifdef MIPS16_RUNCTL_BREAK_EN
  // r_cycles is still zero only in the first RUN cycle, which must not trip the breakpoint
  assign w_bp = bp_en && (pc == bp_addr) && (r_cycles != '0);
`else
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
  assign w_bp        = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_cause    = r_cause;
    w_load_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_load) begin
          if (load_len != '0) w_next = S_LOAD;
        end else if (start_run) begin
          w_next = S_RSTP;
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_next  = S_HALT;
          w_cause = C_ABORT;
        end else if (w_hs && (r_cnt == r_len - (PC_WIDTH+1)'(1))) begin
          w_next     = S_IDLE;
          w_cause    = C_LOAD_DONE;
          w_load_end = 1'b1;
        end
      end
      S_RSTP: begin
        if (abort) begin
          w_next  = S_HALT;
          w_cause = C_ABORT;
        end else if (r_rcnt == RC_LAST) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_next  = S_HALT;
          w_cause = C_ABORT;
        end else if (w_bp) begin
          w_next  = S_HALT;
          w_cause = C_BREAK;
        end else if ((r_limit != '0) && (w_cyc_inc == r_limit)) begin
          w_next  = S_HALT;
          w_cause = C_LIMIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
    w_done_nxt = w_load_end || (w_next == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cause    <= C_LOAD_DONE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_limit    <= '0;
      r_cycles   <= '0;
      r_rcnt     <= '0;
      r_core_rst <= 1'b1;
      r_core_en  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_nxt;
      if (w_done_nxt) r_cause <= w_cause;
      // Core controls decode from the next state; IDLE keeps whatever the last state left
      case (w_next)
        S_LOAD, S_RSTP: begin
          r_core_rst <= 1'b1;
          r_core_en  <= 1'b0;
        end
        S_RUN: begin
          r_core_rst <= 1'b0;
          r_core_en  <= 1'b1;
        end
        S_HALT: begin
          r_core_rst <= 1'b0;
          r_core_en  <= 1'b0;
        end
        default: ;
      endcase
      if (r_state == S_IDLE && w_next == S_LOAD) begin
        r_cnt <= '0;
        r_len <= load_len;
      end else if (w_hs) begin
        r_cnt <= r_cnt + (PC_WIDTH+1)'(1);
      end
      if (r_state == S_IDLE && w_next == S_RSTP) begin
        r_cycles <= '0;
        r_limit  <= run_limit;
        r_rcnt   <= '0;
      end
      if (r_state == S_RSTP) r_rcnt <= r_rcnt + RC_W'(1);
      if (r_state == S_RUN) r_cycles <= w_cyc_inc;
    end
  end

  assign load_ready = (r_state == S_LOAD);
  assign imem_we    = w_hs;
  assign imem_waddr = w_hs ? r_cnt[PC_WIDTH-1:0] : '0;
  assign imem_wdata = w_hs ? load_data : '0;
  assign busy       = (r_state != S_IDLE);
  assign core_rst   = r_core_rst;
  assign core_en    = r_core_en;
  assign done       = r_done;
  assign halt_cause = r_cause;
  assign cycles     = r_cycles;

endmodule

// File: tb/tb_mips_16_run_ctrl.sv
// Randomised self-checking bench for mips_16_run_ctrl: transaction-level model of loads and runs.
module tb_mips_16_run_ctrl;
  localparam int PW = 8;
  localparam int IW = 16;
  localparam int CW = 8;
  localparam int RC = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_load, load_valid, load_ready, imem_we, start_run, abort;
  logic [PW:0]   load_len;
  logic [IW-1:0] load_data, imem_wdata;
  logic [PW-1:0] imem_waddr, pc;
  logic [CW-1:0] run_limit, cycles;
  logic          core_rst, core_en, busy, done;
  logic [1:0]    halt_cause;
`ifdef MIPS16_RUNCTL_BREAK_EN
  logic          bp_en;
  logic [PW-1:0] bp_addr;
`endif

  mips_16_run_ctrl #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .CYC_W(CW), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .load_len(load_len),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .start_run(start_run), .run_limit(run_limit), .abort(abort), .pc(pc),
    .core_rst(core_rst), .core_en(core_en), .busy(busy), .done(done),
    .halt_cause(halt_cause), .cycles(cycles)
`ifdef MIPS16_RUNCTL_BREAK_EN
    , .bp_en(bp_en), .bp_addr(bp_addr)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Instruction memory image as seen through the write port
  logic [IW-1:0] tb_mem [0:255];
  int            we_cnt = 0;
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      tb_mem[imem_waddr] = imem_wdata;
      we_cnt++;
    end
  end

  int pcs [0:511];

  task automatic chk_reset_vals(input string p);
    chk({p, "_core_rst"}, core_rst, 1);
    chk({p, "_core_en"}, core_en, 0);
    chk({p, "_ready"}, load_ready, 0);
    chk({p, "_we"}, imem_we, 0);
    chk({p, "_waddr"}, imem_waddr, 0);
    chk({p, "_wdata"}, imem_wdata, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_cause"}, halt_cause, 0);
    chk({p, "_cycles"}, cycles, 0);
  endtask

  // Loads len words; abort_at>=0 aborts after that many handshakes.
  task automatic do_load(input int len, input int abort_at, input bit with_run);
    logic [IW-1:0] words[$];
    int base, idx, guard, expw;
    for (int i = 0; i < len; i++)
      words.push_back((len == 5) ? IW'((i + 1) * 'h1111) : IW'($urandom));
    expw  = (abort_at >= 0) ? abort_at : len;
    base  = we_cnt;
    idx   = 0;
    guard = 0;
    @(posedge clk); #1;
    start_load = 1'b1; load_len = (PW+1)'(len); start_run = with_run; run_limit = 8'd5;
    @(posedge clk); #1;
    start_load = 1'b0; start_run = 1'b0;
    while (idx < expw && guard < 4 * len + 50) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = words[idx];
      @(negedge clk);
      chk("ld_ready", load_ready, 1);
      if (load_valid) idx++;
      guard++;
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_data  = IW'($urandom);
    chk("ld_guard", idx, expw);
    if (abort_at >= 0) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    @(negedge clk);
    chk("ld_done", done, 1);
    chk("ld_cause", halt_cause, (abort_at >= 0) ? 3 : 0);
    chk("ld_busy", busy, (abort_at >= 0) ? 1 : 0);
    chk("ld_ready_end", load_ready, 0);
    chk("ld_core_en", core_en, 0);
    chk("ld_wcount", we_cnt - base, expw);
    begin
      int bad = 0;
      for (int i = 0; i < expw; i++) if (tb_mem[i] !== words[i]) bad++;
      chk("ld_mem", bad, 0);
    end
    @(negedge clk);
    chk("ld_after_done", done, 0);
    chk("ld_after_busy", busy, 0);
  endtask

  function automatic int first_bp(input int addr);
    for (int k = 2; k < 500; k++) if (pcs[k] == addr) return k;
    return 0;
  endfunction

  // abort_at: RUN cycle (>=2) during which abort is raised, 0 = none. bp_k: expected breakpoint RUN cycle, 0 = none.
  task automatic do_run(input int limit, input int abort_at, input int bp_k);
    int exp_en, exp_cause, c, en, rsth, first_en, budget;
    bit seen;
    exp_en = 1 << 30;
    if (limit != 0) exp_en = limit;
    if (bp_k != 0 && bp_k < exp_en) exp_en = bp_k;
    if (abort_at != 0 && abort_at < exp_en) exp_en = abort_at;
    exp_cause = (abort_at == exp_en) ? 3 : (bp_k == exp_en) ? 2 : 1;
    budget = exp_en + RC + 10;
    c = 0; en = 0; rsth = 0; first_en = 0; seen = 1'b0;
    @(posedge clk); #1;
    start_run = 1'b1; run_limit = CW'(limit);
    @(posedge clk); #1;
    start_run = 1'b0; run_limit = CW'($urandom);
    while (!seen && c < budget) begin
      pc    = PW'(pcs[en + 1]);
      abort = (abort_at != 0) && (en == abort_at - 1);
      @(negedge clk);
      c++;
      if (core_en) begin
        en++;
        if (en == 1) first_en = c;
      end else if (core_rst && en == 0 && !done) begin
        rsth++;
      end
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    abort = 1'b0;
    chk("run_done", seen, 1);
    chk("run_rst_cycles", rsth, RC);
    chk("run_latency", first_en, RC + 1);
    chk("run_en_cycles", en, exp_en);
    chk("run_cause", halt_cause, exp_cause);
    chk("run_cycles", cycles, (exp_en > CMAX) ? CMAX : exp_en);
    chk("run_halt_rst", core_rst, 0);
    chk("run_halt_en", core_en, 0);
    @(negedge clk);
    chk("run_idle_busy", busy, 0);
    chk("run_idle_done", done, 0);
    chk("run_idle_rst", core_rst, 0);
    chk("run_idle_cycles", cycles, (exp_en > CMAX) ? CMAX : exp_en);
    chk("run_idle_cause", halt_cause, exp_cause);
  endtask

  initial begin
    rst = 1'b1; start_load = 1'b0; load_len = '0; load_valid = 1'b0; load_data = '0;
    start_run = 1'b0; run_limit = '0; abort = 1'b0; pc = '0;
`ifdef MIPS16_RUNCTL_BREAK_EN
    bp_en = 1'b0; bp_addr = '0;
`endif
    for (int k = 0; k < 512; k++) pcs[k] = int'($urandom_range(0, 255));
    #12;
    chk_reset_vals("rst0");
    #10 rst = 1'b0;

    do_load(5, -1, 1'b0);
    do_load(256, -1, 1'b0);

    @(posedge clk); #1;
    start_load = 1'b1; load_len = '0;
    @(posedge clk); #1;
    start_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("len0_busy", busy, 0);
      chk("len0_done", done, 0);
    end

    do_run(10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_en", core_en, 0);
      chk("idle_rst", core_rst, 0);
    end
    do_run(0, 37, 0);
    do_load(8, 3, 1'b0);

    for (int it = 0; it < 4; it++) begin
      do_load(int'($urandom_range(1, 40)), -1, 1'b0);
      do_run(int'($urandom_range(1, 60)), ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 70)) : 0, 0);
    end
    do_run(0, 300, 0);
    do_run(255, 0, 0);
    do_run(1, 0, 0);
    do_load(4, -1, 1'b1);

`ifdef MIPS16_RUNCTL_BREAK_EN
    for (int k = 0; k < 512; k++) pcs[k] = (k - 1) & 255;
    pcs[1] = 6;
    bp_en = 1'b1; bp_addr = 8'd6;
    do_run(50, 0, first_bp(6));
    do_run(7, 0, first_bp(6));
    bp_en = 1'b0;
`endif

    @(posedge clk); #1;
    start_run = 1'b1; run_limit = '0;
    @(posedge clk); #1;
    start_run = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_vals("rst_run");
    #3 rst = 1'b0;

    @(posedge clk); #1;
    start_load = 1'b1; load_len = 9'd20;
    @(posedge clk); #1;
    start_load = 1'b0; load_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_vals("rst_load");
    #3 rst = 1'b0;
    @(negedge clk);
    chk("rst_load_we", imem_we, 0);
    load_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
